// File: rtl/pipe_pkg.sv
// Shared types and constants for pipe_stage and its payload slots.
// Optional two-entry skid mode is selected by PIPE_STAGE_SKID_EN.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam int OCC_W = 2;

  // Bubble payload fill bit; all-zero is the MIPS "sll $0,$0,0" encoding.
  localparam logic NOP_DEFAULT_BIT = 1'b0;

  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
    case (s)
      ST_FULL: return 2'd1;
      ST_SKID: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register: clear-to-bubble beats load, otherwise hold.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{NOP_DEFAULT_BIT}}
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = NOP_VAL;
    end else if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/ready handshake and flush.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with registered in_ready.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{NOP_DEFAULT_BIT}}
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  pipe_state_e       state_q;
  pipe_state_e       state_d;
  logic              accept;
  logic              drain;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_src;
  logic [DATA_W-1:0] main_q;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_load;
  logic              skid_clear;
  logic [DATA_W-1:0] skid_q;
  logic              in_ready_q;
  logic              in_ready_d;

  assign in_ready = in_ready_q;
`else
  // Single slot: a full stage can only take a beat while it is draining one.
  assign in_ready = ~out_valid | out_ready;
`endif

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_src   = in_data;
`ifdef PIPE_STAGE_SKID_EN
    skid_load  = 1'b0;
    skid_clear = 1'b0;
`endif
    if (clr | flush) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_clear = 1'b1;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept & drain) begin
            main_load = 1'b1;
          end else if (drain) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (accept) begin
            state_d   = ST_SKID;
            skid_load = 1'b1;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_SKID: begin
          // Older beat leaves; the parked beat moves up to the output slot.
          if (drain) begin
            state_d    = ST_FULL;
            main_load  = 1'b1;
            main_src   = skid_q;
            skid_clear = 1'b1;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
`ifdef PIPE_STAGE_SKID_EN
    in_ready_d = (state_d != ST_SKID);
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
      in_ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
`ifdef PIPE_STAGE_SKID_EN
      in_ready_q <= in_ready_d;
`endif
    end
  end

  pipe_slot #(
    .DATA_W  (DATA_W),
    .NOP_VAL (NOP_VAL)
  ) u_main (
    .clk   (clk),
    .clear (main_clear),
    .load  (main_load),
    .d     (main_src),
    .q     (main_q)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_slot #(
    .DATA_W  (DATA_W),
    .NOP_VAL (NOP_VAL)
  ) u_skid (
    .clk   (clk),
    .clear (skid_clear),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );
`endif

endmodule
